paint_sched: RTL and testbench
==============================

# paint_sched

Brush-stroke scheduler between the SPI command decoder and the canvas frame buffer. Latches brush configuration (size, colour) and, for each position update, expands the brush into a square of pixel writes that it issues to the frame-buffer write port through a request/grant handshake shared with the display side. Holds one pending position while a stroke is in progress and reports busy status.

## Interface
- WIDTH, 160, canvas width in pixels (≤ 256)
- HEIGHT, 120, canvas height in pixels (≤ 256)
- AW, 15, frame-buffer address width; must satisfy 2^AW ≥ WIDTH*HEIGHT
- clk  input  1  system clock; only clock
- reset  input  1  synchronous, active-high reset
- updateConfig  input  1  one-cycle pulse: configuration command valid
- updatePosition  input  1  one-cycle pulse: position command valid
- brushUpdate  input  1  with updateConfig: 1 = set size, 0 = set colour
- x  input  8  brush centre column, valid with updatePosition
- y  input  8  brush centre row, valid with updatePosition
- newColorUpdate  input  3  config payload (size or colour)
- wrGnt  input  1  arbiter grant; a write occurs in any cycle with wrReq & wrGnt
- wrReq  output  1  write request to frame buffer
- waddr  output  AW  pixel address = row*WIDTH + col
- wdata  output  3  pixel colour
- busy  output  1  stroke (or clear) in progress
- dropped  output  1  one-cycle pulse: pending position overwritten

## Operation
- Registers: size[2:0] (brush radius r), color[2:0], pending {pv, px, py}, stroke {cx, cy, sr, scol}, offsets dx, dy.
- updateConfig & brushUpdate: size <= newColorUpdate. updateConfig & !brushUpdate: color <= newColorUpdate. Takes effect at next stroke start; stroke in progress keeps its latched sr/scol.
- updatePosition in IDLE: latch cx=x, cy=y, sr=size, scol=color, dx=dy=-sr; go PAINT.
- updatePosition in PAINT: store into pending; if pv already 1, overwrite and pulse dropped.
- PAINT iterates dy from -sr to +sr (outer), dx from -sr to +sr (inner); pixel (cx+dx, cy+dy) computed in 10-bit signed.
  - In bounds (0 ≤ col < WIDTH, 0 ≤ row < HEIGHT): assert wrReq with waddr/wdata; hold until wrGnt, then advance.
  - Out of bounds: no request, advance in one cycle.
- After last pixel (dx=dy=+sr advanced): if pv, start pending stroke next cycle (pv cleared, same latch rules); else IDLE.
- Simultaneous updatePosition and stroke end: new command goes to pending, which is consumed as usual; pending already valid -> overwrite, dropped.
- Simultaneous updateConfig and stroke start: stroke latches the old size/colour.
- States: IDLE, PAINT, CLEAR (CLEAR only with macro). busy = (state != IDLE).

## Timing
- Reset values: state IDLE, wrReq 0, waddr 0, wdata 0, busy 0, dropped 0, size 0, color 3'b111, pv 0, counters 0.
- updatePosition at cycle t (IDLE) -> busy and first wrReq at t+1 (if first pixel in bounds).
- Full in-bounds stroke with wrGnt held high: (2r+1)^2 write cycles, busy falls the cycle after the last grant.
- waddr/wdata stable while wrReq high and wrGnt low; wrReq never drops without grant except on reset.
- Reset mid-stroke: abort immediately, pending discarded, no further writes.

## Configuration
- PAINT_CLEAR_EN defined: updateConfig & brushUpdate with newColorUpdate = 3'b111 does not change size; instead enters CLEAR (after current stroke, before pending), writing 3'b000 to addresses 0..WIDTH*HEIGHT-1 sequentially under the same handshake, then resumes normal flow. Position commands during CLEAR go to pending.
- Not defined: 3'b111 is an ordinary size (r = 7); CLEAR state absent.

## Test plan
- Reset, set colour 3'b010, size 0, position (10,5), wrGnt=1 -> single write waddr=810, wdata=3'b010, busy high exactly 1 cycle.
- Size 1, position (0,0), wrGnt=1 -> 4 writes at addr 0,1,160,161; 5 skipped pixels; busy 9 cycles.
- Size 1, position (50,50), wrGnt toggling 1/0 -> 9 writes in raster order from addr 7889, waddr/wdata held stable while ungranted.
- During a size-2 stroke issue positions (1,1) then (2,2) -> dropped pulses once; next stroke centred at (2,2); (1,1) never written.
- Assert reset mid-stroke -> wrReq, busy low next cycle; no writes afterwards; pending cleared.
- With PAINT_CLEAR_EN: clear command -> 19200 writes of 3'b000 covering addr 0..19199, then IDLE; without macro same command sets r=7.

Source files
------------

// File: rtl/paint_sched.sv
// paint_sched: expands each brush position into a square of frame-buffer pixel writes.
// Define PAINT_CLEAR_EN to turn size code 3'b111 into a whole-canvas clear command.
module paint_sched #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int AW     = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          updateConfig,
    input  logic          updatePosition,
    input  logic          brushUpdate,
    input  logic [7:0]    x,
    input  logic [7:0]    y,
    input  logic [2:0]    newColorUpdate,
    input  logic          wrGnt,
    output logic          wrReq,
    output logic [AW-1:0] waddr,
    output logic [2:0]    wdata,
    output logic          busy,
    output logic          dropped,
    output logic [1:0]    dbg_state
);

    // Handshake: wrReq/waddr/wdata stay constant until a cycle with wrReq & wrGnt,
    // and the write is taken at the rising edge closing that cycle.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PAINT = 2'd1;
`ifdef PAINT_CLEAR_EN
    localparam logic [1:0]    S_CLEAR   = 2'd2;
    localparam logic [AW-1:0] LAST_ADDR = AW'(WIDTH * HEIGHT - 1);
`endif
    localparam logic [9:0] W10 = 10'(WIDTH);
    localparam logic [9:0] H10 = 10'(HEIGHT);

    logic [1:0]    state;
    logic [2:0]    size, color, sr, scol;
    logic          pv;
    logic [7:0]    px, py, cx, cy;
    logic [3:0]    dx, dy;
    logic [9:0]    col, row;
    logic [AW-1:0] pix_addr;
    logic          inb, adv, row_end, last_px, free, start_new;
    logic          clr_cmd, clr_done;
    logic [7:0]    nx, ny;

`ifdef PAINT_CLEAR_EN
    logic          clr_req, clr_go;
    logic [AW-1:0] caddr;
    assign clr_cmd  = updateConfig & brushUpdate & (newColorUpdate == 3'b111);
    assign clr_done = (state == S_CLEAR) & wrGnt & (caddr == LAST_ADDR);
    assign clr_go   = clr_req | clr_cmd;
`else
    assign clr_cmd  = 1'b0;
    assign clr_done = 1'b0;
`endif

    // Offsets are 4-bit two's complement; the 10-bit sum exposes negatives in bit 9.
    assign col      = {2'b00, cx} + {{6{dx[3]}}, dx};
    assign row      = {2'b00, cy} + {{6{dy[3]}}, dy};
    assign inb      = !col[9] && (col < W10) && !row[9] && (row < H10);
    assign pix_addr = AW'(row) * AW'(WIDTH) + AW'(col);

    assign adv       = (state == S_PAINT) && (!inb || wrGnt);
    assign row_end   = (dx == {1'b0, sr});
    assign last_px   = adv && row_end && (dy == {1'b0, sr});
    assign free      = (state == S_IDLE) || last_px || clr_done;
    assign start_new = updatePosition || pv;
    assign nx        = updatePosition ? x : px;
    assign ny        = updatePosition ? y : py;

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    always_comb begin
        wrReq = (state == S_PAINT) && inb;
        waddr = '0;
        wdata = 3'b000;
        if (wrReq) begin
            waddr = pix_addr;
            wdata = scol;
        end
`ifdef PAINT_CLEAR_EN
        if (state == S_CLEAR) begin
            wrReq = 1'b1;
            waddr = caddr;
            wdata = 3'b000;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            size    <= 3'b000;
            color   <= 3'b111;
            pv      <= 1'b0;
            px      <= 8'd0;
            py      <= 8'd0;
            cx      <= 8'd0;
            cy      <= 8'd0;
            sr      <= 3'b000;
            scol    <= 3'b000;
            dx      <= 4'd0;
            dy      <= 4'd0;
            dropped <= 1'b0;
`ifdef PAINT_CLEAR_EN
            clr_req <= 1'b0;
            caddr   <= '0;
`endif
        end else begin
            dropped <= 1'b0;
            if (updateConfig) begin
                if (!brushUpdate)
                    color <= newColorUpdate;
                else if (!clr_cmd)
                    size <= newColorUpdate;
            end
`ifdef PAINT_CLEAR_EN
            if (clr_cmd)
                clr_req <= 1'b1;
            if (state == S_CLEAR && wrGnt)
                caddr <= caddr + AW'(1);
`endif
            if (free) begin
`ifdef PAINT_CLEAR_EN
                // A queued clear runs before any pending position.
                if (clr_go) begin
                    state   <= S_CLEAR;
                    caddr   <= '0;
                    clr_req <= 1'b0;
                    if (updatePosition) begin
                        pv      <= 1'b1;
                        px      <= x;
                        py      <= y;
                        dropped <= pv;
                    end
                end else
`endif
                if (start_new) begin
                    state   <= S_PAINT;
                    cx      <= nx;
                    cy      <= ny;
                    sr      <= size;
                    scol    <= color;
                    dx      <= 4'd0 - {1'b0, size};
                    dy      <= 4'd0 - {1'b0, size};
                    pv      <= 1'b0;
                    dropped <= updatePosition & pv;
                end else begin
                    state <= S_IDLE;
                end
            end else begin
                if (updatePosition) begin
                    pv      <= 1'b1;
                    px      <= x;
                    py      <= y;
                    dropped <= pv;
                end
                if (adv) begin
                    if (row_end) begin
                        dx <= 4'd0 - {1'b0, sr};
                        dy <= dy + 4'd1;
                    end else begin
                        dx <= dx + 4'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_paint_sched.sv
// tb_paint_sched: randomized and directed stimulus for paint_sched, checked against a
// pixel-list model of each brush stroke.
`timescale 1ns/1ps
module tb_paint_sched;

    localparam int WIDTH  = 160;
    localparam int HEIGHT = 120;
    localparam int AW     = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          updateConfig = 1'b0;
    logic          updatePosition = 1'b0;
    logic          brushUpdate = 1'b0;
    logic [7:0]    x = 8'd0;
    logic [7:0]    y = 8'd0;
    logic [2:0]    newColorUpdate = 3'b000;
    logic          wrGnt = 1'b0;
    logic          wrReq;
    logic [AW-1:0] waddr;
    logic [2:0]    wdata;
    logic          busy;
    logic          dropped;
    logic [1:0]    dbg_state;

    paint_sched #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .AW(AW)) dut (
        .clk(clk), .reset(reset), .updateConfig(updateConfig),
        .updatePosition(updatePosition), .brushUpdate(brushUpdate),
        .x(x), .y(y), .newColorUpdate(newColorUpdate), .wrGnt(wrGnt),
        .wrReq(wrReq), .waddr(waddr), .wdata(wdata), .busy(busy),
        .dropped(dropped), .dbg_state(dbg_state)
    );

    // Clock and grant generation
    always #5 clk = ~clk;

    int gnt_mode = 0;  // 0: always granted, 1: alternate, 2: random
    always @(posedge clk) begin
        #1;
        case (gnt_mode)
            0:       wrGnt = 1'b1;
            1:       wrGnt = ~wrGnt;
            default: wrGnt = 1'($urandom_range(0, 1));
        endcase
    end

    // Scoreboard state
    logic [AW+2:0] exp_q[$];
    int checks = 0;
    int failures = 0;
    int busy_cyc = 0;
    int drop_cnt = 0;
    int writes = 0;
    int cur_size = 0;
    logic [2:0] cur_color = 3'b111;

    logic          hold_prev = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [2:0]    prev_data = 3'b000;

    always @(negedge clk) begin
        logic [AW+2:0] got, exp;
        if (busy === 1'b1) busy_cyc++;
        if (dropped === 1'b1) drop_cnt++;
        if (!reset && wrReq === 1'b1 && wrGnt === 1'b1) begin
            got = {waddr, wdata};
            writes++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write got addr=%0d data=%0d required no write", waddr, wdata);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    failures++;
                    $display("FAIL write got addr=%0d data=%0d required addr=%0d data=%0d",
                             waddr, wdata, exp[AW+2:3], exp[2:0]);
                end
            end
        end
        if (hold_prev && !reset) begin
            checks++;
            if (wrReq !== 1'b1 || waddr !== prev_addr || wdata !== prev_data) begin
                failures++;
                $display("FAIL hold_stable got req=%0b addr=%0d data=%0d required req=1 addr=%0d data=%0d",
                         wrReq, waddr, wdata, prev_addr, prev_data);
            end
        end
        hold_prev = !reset && wrReq === 1'b1 && wrGnt !== 1'b1;
        prev_addr = waddr;
        prev_data = wdata;
    end

    // Reference model: every in-bounds pixel of the square, raster order
    task automatic model_stroke(input int cx, input int cy);
        logic [AW+2:0] e;
        int a;
        for (int dyy = -cur_size; dyy <= cur_size; dyy++)
            for (int dxx = -cur_size; dxx <= cur_size; dxx++)
                if (cx + dxx >= 0 && cx + dxx < WIDTH && cy + dyy >= 0 && cy + dyy < HEIGHT) begin
                    a = (cy + dyy) * WIDTH + cx + dxx;
                    e = {a[AW-1:0], cur_color};
                    exp_q.push_back(e);
                end
    endtask

    task automatic model_clear();
        logic [AW+2:0] e;
        for (int a = 0; a < WIDTH * HEIGHT; a++) begin
            e = {a[AW-1:0], 3'b000};
            exp_q.push_back(e);
        end
    endtask

    // Driver tasks (entered and left at posedge + 1)
    task automatic pulse_pos(input int px, input int py);
        x = px[7:0];
        y = py[7:0];
        updatePosition = 1'b1;
        @(posedge clk); #1;
        updatePosition = 1'b0;
    endtask

    task automatic set_size(input int v);
        updateConfig = 1'b1;
        brushUpdate = 1'b1;
        newColorUpdate = v[2:0];
        @(posedge clk); #1;
        updateConfig = 1'b0;
`ifdef PAINT_CLEAR_EN
        if (v != 7) cur_size = v;
`else
        cur_size = v;
`endif
    endtask

    task automatic set_color(input int v);
        updateConfig = 1'b1;
        brushUpdate = 1'b0;
        newColorUpdate = v[2:0];
        @(posedge clk); #1;
        updateConfig = 1'b0;
        cur_color = v[2:0];
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 40000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_timeout got busy=%0b required 0", name, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_missing_writes got %0d outstanding required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_int(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            failures++;
            $display("FAIL %s got %0d required %0d", name, got, req);
        end
    endtask

    // Scenarios
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 5;
        if (wrReq !== 1'b0) begin failures++; $display("FAIL reset_wrreq got %0b required 0", wrReq); end
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %0b required 0", busy); end
        if (waddr !== '0) begin failures++; $display("FAIL reset_waddr got %0d required 0", waddr); end
        if (wdata !== 3'b000) begin failures++; $display("FAIL reset_wdata got %0d required 0", wdata); end
        if (dropped !== 1'b0) begin failures++; $display("FAIL reset_dropped got %0b required 0", dropped); end
        @(posedge clk); #1;
        reset = 1'b0;
        cur_size = 0;
        cur_color = 3'b111;
    endtask

    task automatic test_single();
        gnt_mode = 0;
        set_color(2);
        set_size(0);
        busy_cyc = 0;
        model_stroke(10, 5);
        pulse_pos(10, 5);
        @(negedge clk);
        checks += 4;
        if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got %0b required 1", busy); end
        if (wrReq !== 1'b1) begin failures++; $display("FAIL single_wrreq got %0b required 1", wrReq); end
        if (waddr !== 15'd810) begin failures++; $display("FAIL single_waddr got %0d required 810", waddr); end
        if (wdata !== 3'b010) begin failures++; $display("FAIL single_wdata got %0d required 2", wdata); end
        @(posedge clk); #1;
        wait_idle("single");
        check_int("single_busy_cycles", busy_cyc, 1);
        check_drained("single");
    endtask

    task automatic test_corner();
        int w0;
        gnt_mode = 0;
        set_size(1);
        busy_cyc = 0;
        w0 = writes;
        model_stroke(0, 0);
        pulse_pos(0, 0);
        wait_idle("corner");
        check_int("corner_busy_cycles", busy_cyc, 9);
        check_int("corner_writes", writes - w0, 4);
        check_drained("corner");
    endtask

    task automatic test_toggle();
        int w0;
        gnt_mode = 1;
        w0 = writes;
        model_stroke(50, 50);
        pulse_pos(50, 50);
        wait_idle("toggle");
        check_int("toggle_writes", writes - w0, 9);
        check_drained("toggle");
        gnt_mode = 0;
    endtask

    task automatic test_dropped();
        gnt_mode = 0;
        set_size(2);
        busy_cyc = 0;
        drop_cnt = 0;
        model_stroke(80, 60);
        pulse_pos(80, 60);
        pulse_pos(1, 1);
        pulse_pos(2, 2);
        model_stroke(2, 2);
        wait_idle("dropped");
        check_int("dropped_pulses", drop_cnt, 1);
        check_int("dropped_busy_cycles", busy_cyc, 50);
        check_drained("dropped");
    endtask

    task automatic test_back_to_back();
        gnt_mode = 0;
        set_color(4);
        set_size(1);
        busy_cyc = 0;
        drop_cnt = 0;
        model_stroke(20, 20);
        pulse_pos(20, 20);
        set_size(0);
        set_color(5);
        pulse_pos(30, 30);
        model_stroke(30, 30);
        wait_idle("b2b");
        check_int("b2b_busy_cycles", busy_cyc, 10);
        check_int("b2b_dropped", drop_cnt, 0);
        check_drained("b2b");
    endtask

    task automatic test_reset_mid();
        int w0;
        gnt_mode = 1;
        set_size(3);
        set_color(6);
        model_stroke(80, 60);
        pulse_pos(80, 60);
        repeat (8) begin @(posedge clk); #1; end
        pulse_pos(5, 5);
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        exp_q.delete();
        cur_size = 0;
        cur_color = 3'b111;
        @(posedge clk); #1;
        @(negedge clk);
        checks += 2;
        if (wrReq !== 1'b0) begin failures++; $display("FAIL midreset_wrreq got %0b required 0", wrReq); end
        if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got %0b required 0", busy); end
        @(posedge clk); #1;
        reset = 1'b0;
        busy_cyc = 0;
        w0 = writes;
        repeat (30) begin @(posedge clk); #1; end
        check_int("midreset_idle_busy", busy_cyc, 0);
        check_int("midreset_idle_writes", writes - w0, 0);
        gnt_mode = 0;
        model_stroke(7, 7);
        pulse_pos(7, 7);
        wait_idle("postreset");
        check_drained("postreset");
    endtask

    task automatic test_size7();
        int w0;
        gnt_mode = 0;
        busy_cyc = 0;
        w0 = writes;
`ifdef PAINT_CLEAR_EN
        set_size(2);
        model_clear();
        set_size(7);
        wait_idle("clear");
        check_int("clear_busy_cycles", busy_cyc, WIDTH * HEIGHT);
        check_int("clear_writes", writes - w0, WIDTH * HEIGHT);
        check_drained("clear");
        busy_cyc = 0;
        model_stroke(80, 60);
        pulse_pos(80, 60);
        wait_idle("after_clear");
        check_int("after_clear_busy_cycles", busy_cyc, 25);
        check_drained("after_clear");
`else
        set_size(7);
        model_stroke(80, 60);
        pulse_pos(80, 60);
        wait_idle("size7");
        check_int("size7_busy_cycles", busy_cyc, 225);
        check_int("size7_writes", writes - w0, 225);
        check_drained("size7");
`endif
    endtask

    task automatic test_random();
        gnt_mode = 2;
        for (int i = 0; i < 12; i++) begin
            set_size($urandom_range(0, 6));
            if ($urandom_range(0, 1) == 1) set_color($urandom_range(0, 7));
            model_stroke($urandom_range(0, 175), $urandom_range(0, 135));
            pulse_pos(int'(dut_x_of_last()), 0);
        end
    endtask

    // Centre of the most recent random stroke
    int last_x = 0;
    int last_y = 0;
    function automatic int dut_x_of_last();
        return last_x;
    endfunction

    task automatic test_random_strokes();
        gnt_mode = 2;
        for (int i = 0; i < 12; i++) begin
            set_size($urandom_range(0, 6));
            if ($urandom_range(0, 1) == 1) set_color($urandom_range(0, 7));
            last_x = $urandom_range(0, 175);
            last_y = $urandom_range(0, 135);
            model_stroke(last_x, last_y);
            pulse_pos(last_x, last_y);
            wait_idle("random");
            check_drained("random");
        end
        gnt_mode = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_corner();
        test_toggle();
        test_dropped();
        test_back_to_back();
        test_reset_mid();
        test_size7();
        test_random_strokes();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
